// File: rtl/line_ring_scheduler_pkg.sv
// Shared constants and state encoding for the mapping-layer line-buffer ring.
package line_ring_scheduler_pkg;

  localparam int IMG_W     = 320;
  localparam int IMG_H     = 180;
  localparam int NUM_BANKS = 4;
  localparam int ROW_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_RUN  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/line_ring_scheduler.sv
// Line-buffer ring sequencer: grants line writes into the bank ring, launches one
// 3-row window read pass per output row, and frees banks as passes complete.
module line_ring_scheduler
  import line_ring_scheduler_pkg::*;
#(
  parameter int IMG_H     = line_ring_scheduler_pkg::IMG_H,
  parameter int NUM_BANKS = line_ring_scheduler_pkg::NUM_BANKS,
  parameter int ROW_W     = line_ring_scheduler_pkg::ROW_W
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_frame_start,
  input  logic                           i_wr_line_done,
  output logic                           o_wr_allow,
  output logic [$clog2(NUM_BANKS)-1:0]   o_wr_bank,
  input  logic                           i_rd_ready,
  output logic                           o_rd_start,
  output logic [$clog2(NUM_BANKS)-1:0]   o_rd_base_bank,
  output logic [ROW_W-1:0]               o_rd_row,
  output logic                           o_pad_top,
  output logic                           o_pad_bot,
  input  logic                           i_rd_row_done,
  output logic [$clog2(NUM_BANKS+1)-1:0] o_lines_stored,
  output logic                           o_busy,
  output logic                           o_frame_done,
  output logic                           o_err
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam int OW = $clog2(NUM_BANKS+1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W:0]   LINES    = (ROW_W+1)'(IMG_H);

  state_t           state, state_nxt;
  logic [ROW_W-1:0] wr_cnt, rd_row;
  logic [OW-1:0]    occ;
  logic [ROW_W:0]   need;
  logic             busy, wr_allow, wr_acc, launch, done_acc, last_done, rel_one;

  // Event qualification: write grant, launch compare and row-done decode
  always_comb begin
    need = {1'b0, rd_row} + (ROW_W+1)'(2);
    if (need > LINES) need = LINES;
    busy      = (state != S_IDLE);
    wr_allow  = busy && (occ < OW'(NUM_BANKS)) && ({1'b0, wr_cnt} < LINES);
    wr_acc    = i_wr_line_done && wr_allow;
    // FILL can launch directly once two lines are in, so row 0 starts one cycle after wr_cnt=2
    launch    = (state == S_RUN || (state == S_FILL && wr_cnt >= ROW_W'(2))) &&
                i_rd_ready && ({1'b0, wr_cnt} >= need);
    done_acc  = i_rd_row_done && (state == S_WAIT);
    last_done = done_acc && (rd_row == ROW_LAST);
    rel_one   = done_acc && (rd_row != '0);
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (i_frame_start) state_nxt = S_FILL;
      S_FILL: if (launch) state_nxt = S_WAIT;
              else if (wr_cnt >= ROW_W'(2)) state_nxt = S_RUN;
      S_RUN:  if (launch) state_nxt = S_WAIT;
      S_WAIT: if (done_acc) state_nxt = last_done ? S_DONE : S_RUN;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    o_busy         = busy;
    o_frame_done   = (state == S_DONE);
    o_wr_allow     = wr_allow;
    o_wr_bank      = wr_cnt[BW-1:0];
    o_lines_stored = occ;
  end

  // Line/row counters and ring occupancy; counters clear on frame entry
  always_ff @(posedge i_clk) begin
    if (i_rst || (state == S_IDLE && i_frame_start)) begin
      wr_cnt <= '0;
      rd_row <= '0;
      occ    <= '0;
    end else begin
      if (wr_acc) wr_cnt <= wr_cnt + ROW_W'(1);
      if (done_acc && !last_done) rd_row <= rd_row + ROW_W'(1);
      // last row frees every bank; otherwise a write and a release cancel out
      if (last_done)             occ <= '0;
      else if (wr_acc && !rel_one) occ <= occ + OW'(1);
      else if (!wr_acc && rel_one) occ <= occ - OW'(1);
    end
  end

  // Pass launch: registered start pulse with pass descriptor held until next launch
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_start     <= 1'b0;
      o_rd_row       <= '0;
      o_rd_base_bank <= '0;
      o_pad_top      <= 1'b0;
      o_pad_bot      <= 1'b0;
    end else begin
      o_rd_start <= launch;
      if (launch) begin
        o_rd_row       <= rd_row;
        o_rd_base_bank <= rd_row[BW-1:0] - BW'(1);
        o_pad_top      <= (rd_row == '0);
        o_pad_bot      <= (rd_row == ROW_LAST);
      end
    end
  end

  // Sticky protocol error; offending events are dropped by the qualifiers above
  always_ff @(posedge i_clk) begin
    if (i_rst) o_err <= 1'b0;
    else if ((i_wr_line_done && !wr_allow) ||
             (i_rd_row_done && state != S_WAIT) ||
             (i_frame_start && busy))
      o_err <= 1'b1;
  end

endmodule
